// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, add/sub ALU, operand sign extension,
// data RAM and registered Zero/Neg/Ovf flags, driven by decoded control signals.
module bip_datapath #(
  parameter int len_data  = 16,
  parameter int len_addr  = 11,
  parameter int len_mux_a = 2,
  parameter int ram_depth = 2048
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [len_mux_a-1:0] SelA,
  input  logic                 SelB,
  input  logic                 WrAcc,
  input  logic                 Op,
  input  logic                 WrRam,
  input  logic                 RdRam,
  input  logic [len_addr-1:0]  Operand,
  output logic [len_data-1:0]  Acc,
  output logic                 Zero,
  output logic                 Neg,
  output logic                 Ovf
);

  typedef enum logic [len_mux_a-1:0] {
    SEL_RAM  = 2'b00,
    SEL_IMM  = 2'b01,
    SEL_ALU  = 2'b10,
    SEL_HOLD = 2'b11
  } sel_a_e;

  localparam int MSB = len_data - 1;

  logic [len_data-1:0] mem [ram_depth];

  logic [len_data-1:0] acc_q, acc_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;

  sel_a_e              sel_a;
  logic [len_data-1:0] imm;
  logic [len_data-1:0] ram_data;
  logic [len_data-1:0] alu_b;
  logic [len_data-1:0] alu_res;
  logic                alu_ovf;

  assign sel_a    = sel_a_e'(SelA);
  assign imm      = {{(len_data-len_addr){Operand[len_addr-1]}}, Operand};
  assign ram_data = RdRam ? mem[Operand] : '0;
  assign alu_b    = SelB ? imm : ram_data;

  // Overflow is judged against the pre-edge accumulator sign: a result whose
  // sign departs from Acc is only illegal when the operand signs allowed it.
  always_comb begin
    alu_res = Op ? (acc_q - alu_b) : (acc_q + alu_b);
    alu_ovf = (alu_res[MSB] != acc_q[MSB]) &&
              (Op ? (acc_q[MSB] != alu_b[MSB]) : (acc_q[MSB] == alu_b[MSB]));
  end

  always_comb begin
    acc_d  = acc_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    if (WrAcc) begin
      unique case (sel_a)
        SEL_RAM:  acc_d = ram_data;
        SEL_IMM:  acc_d = imm;
        SEL_ALU:  acc_d = alu_res;
        SEL_HOLD: acc_d = acc_q;
        default:  acc_d = acc_q;
      endcase
      zero_d = (acc_d == '0);
      neg_d  = acc_d[MSB];
      ovf_d  = (sel_a == SEL_ALU) ? alu_ovf : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  // RAM is never cleared; the reset term only blocks stores while reset is held.
  always_ff @(posedge clk) begin
    if (WrRam && reset) begin
      mem[Operand] <= acc_q;
    end
  end

  assign Acc  = acc_q;
  assign Zero = zero_q;
  assign Neg  = neg_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Self-checking bench for bip_datapath: hand-computed vector table run through
// an expected-result queue, plus directed reset sequences.
module tb_bip_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  SelA;
  logic        SelB, WrAcc, Op, WrRam, RdRam;
  logic [10:0] Operand;
  logic [15:0] Acc;
  logic        Zero, Neg, Ovf;

  always #5 clk = ~clk;

  bip_datapath #(
    .len_data (16),
    .len_addr (11),
    .len_mux_a(2),
    .ram_depth(2048)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .SelA   (SelA),
    .SelB   (SelB),
    .WrAcc  (WrAcc),
    .Op     (Op),
    .WrRam  (WrRam),
    .RdRam  (RdRam),
    .Operand(Operand),
    .Acc    (Acc),
    .Zero   (Zero),
    .Neg    (Neg),
    .Ovf    (Ovf)
  );

  // f = {Zero, Neg, Ovf}
  typedef struct {
    logic [1:0]  sa;
    logic        sb, wa, op, wr, rd;
    logic [10:0] opnd;
    logic [15:0] acc;
    logic [2:0]  f;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    logic [2:0]  f;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic [1:0] sa, logic sb, logic wa, logic op, logic wr,
                              logic rd, logic [10:0] opnd, logic [15:0] acc, logic [2:0] f);
    vec_t v;
    v.sa = sa; v.sb = sb; v.wa = wa; v.op = op; v.wr = wr; v.rd = rd;
    v.opnd = opnd; v.acc = acc; v.f = f;
    return v;
  endfunction

  function automatic vec_t ldi(logic [10:0] o, logic [15:0] a, logic [2:0] f);
    return mk(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, o, a, f);
  endfunction
  function automatic vec_t sto(logic [10:0] o, logic [15:0] a, logic [2:0] f);
    return mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, o, a, f);
  endfunction
  function automatic vec_t ld(logic [10:0] o, logic [15:0] a, logic [2:0] f);
    return mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, o, a, f);
  endfunction
  function automatic vec_t add(logic [10:0] o, logic [15:0] a, logic [2:0] f);
    return mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, o, a, f);
  endfunction
  function automatic vec_t sub(logic [10:0] o, logic [15:0] a, logic [2:0] f);
    return mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, o, a, f);
  endfunction
  function automatic vec_t addi(logic [10:0] o, logic [15:0] a, logic [2:0] f);
    return mk(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, o, a, f);
  endfunction
  function automatic vec_t subi(logic [10:0] o, logic [15:0] a, logic [2:0] f);
    return mk(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, o, a, f);
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(vec_t v, string tag);
    @(negedge clk);
    SelA = v.sa; SelB = v.sb; WrAcc = v.wa; Op = v.op;
    WrRam = v.wr; RdRam = v.rd; Operand = v.opnd;
    sbq.push_back('{acc: v.acc, f: v.f, tag: tag});
  endtask

  task automatic collect();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      check({e.tag, "_acc"}, Acc, e.acc);
      check({e.tag, "_flags"}, {13'd0, Zero, Neg, Ovf}, {13'd0, e.f});
    end
  endtask

  task automatic step(vec_t v, string tag);
    drive(v, tag);
    collect();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    SelA = 2'b11; SelB = 1'b0; WrAcc = 1'b0; Op = 1'b0;
    WrRam = 1'b0; RdRam = 1'b0; Operand = '0;
    #1 reset = 1'b0;
    #11;
    check("reset_acc", Acc, 16'h0000);
    check("reset_flags", {13'd0, Zero, Neg, Ovf}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    tbl.push_back(ldi(11'h7FF, 16'hFFFF, 3'b010));
    tbl.push_back(ldi(11'h3FF, 16'h03FF, 3'b000));
    tbl.push_back(ldi(11'h0A5, 16'h00A5, 3'b000));
    tbl.push_back(sto(11'h010, 16'h00A5, 3'b000));
    tbl.push_back(ldi(11'h000, 16'h0000, 3'b100));
    tbl.push_back(ld (11'h010, 16'h00A5, 3'b000));
    tbl.push_back(ldi(11'h400, 16'hFC00, 3'b010));
    tbl.push_back(sto(11'h040, 16'hFC00, 3'b010));
    tbl.push_back(add(11'h040, 16'hF800, 3'b010));
    tbl.push_back(sto(11'h040, 16'hF800, 3'b010));
    tbl.push_back(add(11'h040, 16'hF000, 3'b010));
    tbl.push_back(sto(11'h040, 16'hF000, 3'b010));
    tbl.push_back(add(11'h040, 16'hE000, 3'b010));
    tbl.push_back(sto(11'h040, 16'hE000, 3'b010));
    tbl.push_back(add(11'h040, 16'hC000, 3'b010));
    tbl.push_back(sto(11'h040, 16'hC000, 3'b010));
    tbl.push_back(add(11'h040, 16'h8000, 3'b010));
    tbl.push_back(subi(11'h001, 16'h7FFF, 3'b001));
    tbl.push_back(addi(11'h001, 16'h8000, 3'b011));
    tbl.push_back(sto(11'h041, 16'h8000, 3'b011));
    tbl.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 16'h8000, 3'b011));
    tbl.push_back(ldi(11'h002, 16'h0002, 3'b000));
    tbl.push_back(ldi(11'h005, 16'h0005, 3'b000));
    tbl.push_back(sto(11'h003, 16'h0005, 3'b000));
    tbl.push_back(sub(11'h003, 16'h0000, 3'b100));
    tbl.push_back(ldi(11'h7FF, 16'hFFFF, 3'b010));
    tbl.push_back(addi(11'h001, 16'h0000, 3'b100));
    tbl.push_back(ldi(11'h005, 16'h0005, 3'b000));
    tbl.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010, 16'h0000, 3'b100));
    tbl.push_back(ldi(11'h7FF, 16'hFFFF, 3'b010));
    tbl.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 16'hFFFF, 3'b010));
    tbl.push_back(ldi(11'h011, 16'h0011, 3'b000));
    tbl.push_back(mk(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'h020, 16'h0020, 3'b000));
    tbl.push_back(sto(11'h021, 16'h0020, 3'b000));
    tbl.push_back(ld (11'h020, 16'h0011, 3'b000));
    tbl.push_back(ld (11'h021, 16'h0020, 3'b000));
    tbl.push_back(ld (11'h041, 16'h8000, 3'b010));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle with a pending store to mem[5].
    step(ldi(11'h055, 16'h0055, 3'b000), "rs_ldi55");
    step(sto(11'h005, 16'h0055, 3'b000), "rs_sto5");
    step(ldi(11'h200, 16'h0200, 3'b000), "rs_ldi200");
    step(sto(11'h006, 16'h0200, 3'b000), "rs_sto6a");
    step(add(11'h006, 16'h0400, 3'b000), "rs_dbl1");
    step(sto(11'h006, 16'h0400, 3'b000), "rs_sto6b");
    step(add(11'h006, 16'h0800, 3'b000), "rs_dbl2");
    step(sto(11'h006, 16'h0800, 3'b000), "rs_sto6c");
    step(add(11'h006, 16'h1000, 3'b000), "rs_dbl3");
    step(addi(11'h234, 16'h1234, 3'b000), "rs_addi");

    @(negedge clk);
    SelA = 2'b11; WrAcc = 1'b0; WrRam = 1'b1; RdRam = 1'b0; Operand = 11'h005;
    #2 reset = 1'b0;
    #1;
    check("async_reset_acc", Acc, 16'h0000);
    check("async_reset_flags", {13'd0, Zero, Neg, Ovf}, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_hold_acc", Acc, 16'h0000);
    @(negedge clk);
    WrRam = 1'b0;
    reset = 1'b1;
    step(ld(11'h005, 16'h0055, 3'b000), "rs_mem5_kept");
    step(ld(11'h006, 16'h0800, 3'b000), "rs_mem6");

    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_datapath.md
# bip_datapath

Execution datapath of the single-cycle BIP processor, directly downstream of the control unit. Consumes the control unit's decoded signals (SelA, SelB, WrAcc, Op, WrRam, RdRam) and 11-bit Operand. Holds the accumulator, the add/sub unit, the operand sign extender, the data RAM and a registered status-flag set. Exposes the accumulator and flags to the top level and debug logic.

## Interface
- len_data, 16, accumulator / RAM word width
- len_addr, 11, operand and data-RAM address width
- len_mux_a, 2, width of SelA
- ram_depth, 2048, data-RAM words (= 2**len_addr)

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- SelA  in  len_mux_a  accumulator input select
- SelB  in  1  ALU B-operand select
- WrAcc  in  1  accumulator write enable
- Op  in  1  ALU operation: 0 add, 1 subtract
- WrRam  in  1  data-RAM write enable
- RdRam  in  1  data-RAM read enable
- Operand  in  len_addr  instruction operand: RAM address or immediate
- Acc  out  len_data  current accumulator value
- Zero  out  1  registered: last written Acc == 0
- Neg  out  1  registered: last written Acc MSB
- Ovf  out  1  registered: signed overflow of last ALU write

## Operation
- Sign extension: Imm = {(len_data-len_addr) copies of Operand[len_addr-1], Operand}.
- RAM read: combinational. RamData = RdRam ? mem[Operand] : 0.
- RAM write: at rising edge when WrRam=1 and reset=1, mem[Operand] <= Acc (pre-edge value). RAM contents are not cleared by reset; reset does not itself write.
- B operand: SelB=0 -> RamData; SelB=1 -> Imm.
- ALU: Res = Op ? Acc - B : Acc + B, truncated to len_data bits (modulo 2^len_data).
- Signed overflow: add -> Acc and B same sign, Res sign differs; sub -> Acc and B signs differ, Res sign differs from Acc.
- Acc input mux: SelA=00 -> RamData (LD); 01 -> Imm (LDI); 10 -> Res (ADD/ADDI/SUB/SUBI); 11 -> Acc (hold).
- On rising edge with WrAcc=1: Acc <= mux output, Zero <= (mux output == 0), Neg <= mux output MSB, Ovf <= (SelA==10) ? overflow : 0.
- WrAcc=0: Acc and all flags hold. STO (WrRam=1, WrAcc=0) leaves flags unchanged.
- Accumulator is the only register in the Acc path. No handshake; every cycle is one instruction.

## Timing
- Reset (reset=0, asynchronous): Acc=0, Zero=0, Neg=0, Ovf=0 immediately, independent of clk. All writes suppressed while reset=0. After deassertion, the first rising edge with reset=1 performs normal updates.
- Reset asserted mid-cycle between a WrRam setup and the edge: no RAM write occurs.
- Latency: control inputs to Acc/flags take effect at the next rising edge (1 cycle). RamData and Res are combinational from Operand/Acc within the same cycle.
- Read-after-write, same address, consecutive cycles: the cycle after STO, LD returns the stored value.
- Simultaneous WrRam and WrAcc in one cycle: RAM receives the old Acc; Acc takes the new value.
- RdRam=0 with SelA=00 and WrAcc=1: Acc <= 0, Zero <= 1.
- Operand address range: 0..ram_depth-1. No out-of-range case exists at the defaults.
- Wrap-around: 0x7FFF+1 -> 0x8000 with Ovf=1. 0xFFFF+1 -> 0x0000 with Ovf=0 and Zero=1.

## Test plan
- Reset: drive reset=0 mid-cycle with Acc=0x1234 -> Acc=0, Zero=Neg=Ovf=0 without a clock edge. A WrRam edge during reset leaves mem[5] unchanged.
- LDI sign extension: Operand=0x7FF, SelA=01, WrAcc=1 -> Acc=0xFFFF, Neg=1, Zero=0. Operand=0x3FF -> Acc=0x03FF, Neg=0.
- STO/LD: Acc=0x00A5, WrRam=1, Operand=0x010. Next cycle RdRam=1, SelA=00, WrAcc=1 at Operand=0x010 after clearing Acc via LDI 0 -> Acc=0x00A5.
- ADDI overflow: Acc=0x7FFF, Operand=1, SelB=1, Op=0, SelA=10, WrAcc=1 -> Acc=0x8000, Ovf=1, Neg=1. Then LDI 2 -> Ovf=0.
- SUB from RAM: mem[3]=0x0005, Acc=0x0005, SelB=0, RdRam=1, Op=1, SelA=10 -> Acc=0, Zero=1, Ovf=0. Then 0x8000 - 1 (SUBI) -> 0x7FFF, Ovf=1.
- Same-edge STO+LDI: Acc=0x0011, WrRam=1 at Operand=0x020, SelA=01, WrAcc=1 -> mem[0x020]=0x0011 and Acc=0x0020. Flags hold through a following STO-only cycle.
